loopback_multi_pu: RTL and testbench

LOOPBACK_MULTI_PU -- requirements
Module: loopback_multi_pu

---
 rtl/loopback_multi_pu.sv | 180 ++++++++++++++++++
 tb/tb_loopback_multi_pu.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/loopback_multi_pu.sv
// Loopback engine: pops stream (and optional buffer) words, applies a
// per-mode operation and pushes the result to one or all PU lanes.
module loopback_multi_pu #(
  parameter int NUM_PU     = 4,
  parameter int NUM_PE     = 4,
  parameter int OP_WIDTH   = 16,
  parameter int BUF_DATA_W = 64,
  parameter int CNT_W      = 20,
  localparam int PU_DATA_W = NUM_PE * OP_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [CNT_W-1:0]            num_words,
  input  logic                        stream_read_ready,
  output logic                        stream_read_req,
  input  logic [PU_DATA_W-1:0]        stream_read_data,
  input  logic                        buffer_read_ready,
  output logic                        buffer_read_req,
  input  logic [BUF_DATA_W-1:0]       buffer_read_data,
  output logic [NUM_PU-1:0]           stream_write_req,
  output logic [NUM_PU*PU_DATA_W-1:0] stream_write_data,
  input  logic [NUM_PU-1:0]           stream_write_ready,
  output logic                        done,
  output logic                        busy,
  output logic [1:0]                  state,
  output logic [CNT_W-1:0]            words_read,
  output logic [CNT_W-1:0]            words_written
);

  localparam int PSEL_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [1:0]           r_mode;
  logic [CNT_W-1:0]     r_num_words;
  logic [CNT_W-1:0]     r_words_read;
  logic [CNT_W-1:0]     r_words_written;
  logic [PSEL_W-1:0]    r_pu_sel;
  logic                 r_out_valid;
  logic [PU_DATA_W-1:0] r_out_data;
  logic [NUM_PU-1:0]    r_out_mask;

  logic                 w_start_job;
  logic                 w_mode_buf;
  logic                 w_fire;
  logic                 w_pop;
  logic [PU_DATA_W-1:0] w_buf_lo;
  logic [PU_DATA_W-1:0] w_result;
  logic [NUM_PU-1:0]    w_onehot;

  assign w_start_job = (r_state == S_IDLE) && start;
  assign w_mode_buf  = (r_mode == 2'd1) || (r_mode == 2'd2);
  assign w_buf_lo    = buffer_read_data[PU_DATA_W-1:0];

  // A push only happens when every targeted lane can accept it.
  assign w_fire = r_out_valid &&
                  ((r_out_mask & stream_write_ready) == r_out_mask);

  // Pop when running, words remain, sources ready and output slot frees.
  assign w_pop = !reset && (r_state == S_RUN) &&
                 (r_words_read < r_num_words) &&
                 stream_read_ready &&
                 (buffer_read_ready || !w_mode_buf) &&
                 (!r_out_valid || w_fire);

  assign stream_read_req  = w_pop;
  assign buffer_read_req  = w_pop && w_mode_buf;
  assign stream_write_req = (!reset && w_fire) ? r_out_mask : '0;
  assign stream_write_data = {NUM_PU{r_out_data}};
  assign words_read    = r_words_read;
  assign words_written = r_words_written;

  // Per-mode datapath; add is lane-wise with no carry between operands.
  always_comb begin
    w_result = stream_read_data;
    unique case (r_mode)
      2'd1: begin
        for (int i = 0; i < NUM_PE; i++) begin
          w_result[i*OP_WIDTH +: OP_WIDTH] =
            stream_read_data[i*OP_WIDTH +: OP_WIDTH] +
            w_buf_lo[i*OP_WIDTH +: OP_WIDTH];
        end
      end
      2'd2:    w_result = stream_read_data ^ w_buf_lo;
      default: w_result = stream_read_data;
    endcase
  end

  // One-hot decode of the current PU selector.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_PU; i++) begin
      w_onehot[i] = (r_pu_sel == PSEL_W'(i));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (num_words == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_words_read == r_num_words) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_words_written == r_num_words) w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    state = r_state;
    done  = (r_state == S_DONE);
    busy  = (r_state == S_RUN) || (r_state == S_DRAIN);
  end

  // Job parameters, counters and the lane selector.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode          <= 2'd0;
      r_num_words     <= '0;
      r_words_read    <= '0;
      r_words_written <= '0;
      r_pu_sel        <= '0;
    end else if (w_start_job) begin
      r_mode          <= mode;
      r_num_words     <= num_words;
      r_words_read    <= '0;
      r_words_written <= '0;
      r_pu_sel        <= '0;
    end else begin
      if (w_pop) begin
        r_words_read <= r_words_read + CNT_W'(1);
        if (r_mode != 2'd3) begin
          if (r_pu_sel == PSEL_W'(NUM_PU - 1)) r_pu_sel <= '0;
          else                                 r_pu_sel <= r_pu_sel + PSEL_W'(1);
        end
      end
      if (w_fire) begin
        r_words_written <= r_words_written + CNT_W'(1);
      end
    end
  end

  // Output register: load on pop (even while firing), clear on a lone fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mask  <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_mask  <= (r_mode == 2'd3) ? {NUM_PU{1'b1}} : w_onehot;
    end else if (w_fire) begin
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
    end
  end

endmodule

// File: tb/tb_loopback_multi_pu.sv
// Bench for loopback_multi_pu: directed jobs plus randomized readiness,
// with a word-level scoreboard of expected pushes.
module tb_loopback_multi_pu;

  localparam int NPU = 4;
  localparam int PDW = 64;
  localparam int BDW = 64;
  localparam int CW  = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        mode;
  logic [CW-1:0]     num_words;
  logic              stream_read_ready;
  logic              stream_read_req;
  logic [PDW-1:0]    stream_read_data;
  logic              buffer_read_ready;
  logic              buffer_read_req;
  logic [BDW-1:0]    buffer_read_data;
  logic [NPU-1:0]    stream_write_req;
  logic [NPU*PDW-1:0] stream_write_data;
  logic [NPU-1:0]    stream_write_ready;
  logic              done;
  logic              busy;
  logic [1:0]        state;
  logic [CW-1:0]     words_read;
  logic [CW-1:0]     words_written;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sarr [0:255];
  logic [63:0] barr [0:255];
  logic [63:0] got_data [$];
  logic [3:0]  got_mask [$];
  int          done_cyc;
  int          first_push_cyc;

  loopback_multi_pu dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .num_words(num_words),
    .stream_read_ready(stream_read_ready),
    .stream_read_req(stream_read_req),
    .stream_read_data(stream_read_data),
    .buffer_read_ready(buffer_read_ready),
    .buffer_read_req(buffer_read_req),
    .buffer_read_data(buffer_read_data),
    .stream_write_req(stream_write_req),
    .stream_write_data(stream_write_data),
    .stream_write_ready(stream_write_ready),
    .done(done), .busy(busy), .state(state),
    .words_read(words_read), .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] expect_word(input logic [1:0] m,
                                              input logic [63:0] s,
                                              input logic [63:0] b);
    logic [63:0] r;
    r = s;
    if (m == 2'd1) begin
      for (int i = 0; i < 4; i++) r[i*16 +: 16] = s[i*16 +: 16] + b[i*16 +: 16];
    end else if (m == 2'd2) begin
      r = s ^ b;
    end
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      sarr[i] = {$urandom, $urandom};
      barr[i] = {$urandom, $urandom};
    end
  endtask

  // Runs one job from IDLE; begins and ends just after a rising edge.
  task automatic run_job(input logic [1:0] m, input int n,
                         input int pr_s, input int pr_b, input int pr_o,
                         input int stall_n, input logic [3:0] stall_rdy);
    int rd;
    int wr;
    logic bufm;
    logic [63:0] e;
    got_data.delete();
    got_mask.delete();
    done_cyc = -1;
    first_push_cyc = -1;
    bufm = (m == 2'd1) || (m == 2'd2);
    rd = 0;
    wr = 0;
    mode = m;
    num_words = CW'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 2'($urandom);
    num_words = CW'($urandom);
    for (int cyc = 0; cyc < n * 20 + 40; cyc++) begin
      stream_read_ready = ($urandom_range(99) < pr_s);
      buffer_read_ready = ($urandom_range(99) < pr_b);
      if (cyc < stall_n) stream_write_ready = stall_rdy;
      else if ($urandom_range(99) < pr_o) stream_write_ready = 4'hF;
      else stream_write_ready = 4'($urandom);
      stream_read_data = sarr[rd % 256];
      buffer_read_data = barr[rd % 256];
      @(negedge clk);
      if (cyc == 0) begin
        chk("busy_start", busy, n > 0);
        chk("state_start", state, (n > 0) ? 2'd1 : 2'd3);
      end
      chk("buf_req", buffer_read_req, stream_read_req & bufm);
      if (stream_read_req) begin
        chk("pop_ok", {rd < n, stream_read_ready,
                       buffer_read_ready | !bufm}, 3'b111);
        rd++;
      end
      if (stream_write_req != '0) begin
        if (first_push_cyc < 0) first_push_cyc = cyc;
        chk("push_ready", stream_write_req & ~stream_write_ready, 0);
        chk("push_count", wr < n, 1);
        e = expect_word(m, sarr[wr % 256], barr[wr % 256]);
        chk("push_mask", stream_write_req,
            (m == 2'd3) ? 4'hF : 4'(1 << (wr % 4)));
        for (int l = 0; l < NPU; l++)
          chk("push_data", stream_write_data[l*PDW +: PDW], e);
        got_data.push_back(stream_write_data[63:0]);
        got_mask.push_back(stream_write_req);
        wr++;
      end
      if (done) done_cyc = cyc;
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    chk("done_seen", done_cyc >= 0, 1);
    chk("rd_total", rd, n);
    chk("wr_total", wr, n);
    chk("words_read", words_read, n);
    chk("words_written", words_written, n);
    @(negedge clk);
    chk("done_one_cycle", {done, state}, 3'b000);
    chk("counter_hold", words_read, n);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    num_words = '0;
    stream_read_ready = 1'b0;
    buffer_read_ready = 1'b0;
    stream_write_ready = 4'hF;
    stream_read_data = '0;
    buffer_read_data = '0;
    fill_random();
    repeat (2) @(posedge clk);
    #1;
    stream_read_ready = 1'b1;
    buffer_read_ready = 1'b1;
    @(negedge clk);
    chk("rst_state", state, 2'd0);
    chk("rst_flags", {done, busy}, 2'b00);
    chk("rst_reqs", {stream_read_req, buffer_read_req, stream_write_req}, 0);
    chk("rst_counts", {words_read, words_written}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Mode 0, all ready: lanes walk 1,2,4,8,1,2 at full rate.
    run_job(2'd0, 6, 100, 100, 100, 0, 4'hF);
    chk("done_latency", done_cyc, 8);
    chk("push_seq_len", got_mask.size(), 6);
    if (got_mask.size() == 6)
      chk("push_seq", {got_mask[0], got_mask[1], got_mask[2], got_mask[3],
                       got_mask[4], got_mask[5]}, 24'h124812);

    // Mode 1: lane wrap without carry into the neighbour.
    fill_random();
    sarr[0] = 64'h1111_2222_3333_FFFF;
    barr[0] = 64'h0001_0001_0001_0002;
    run_job(2'd1, 4, 100, 100, 100, 0, 4'hF);
    if (got_data.size() > 0)
      chk("add_nocarry", got_data[0], 64'h1112_2223_3334_0001);

    // Mode 3 with lane 2 stalled for five cycles.
    fill_random();
    run_job(2'd3, 2, 100, 100, 100, 5, 4'b1011);
    chk("bcast_first_push", first_push_cyc, 5);
    chk("bcast_count", got_mask.size(), 2);
    if (got_mask.size() == 2)
      chk("bcast_masks", {got_mask[0], got_mask[1]}, 8'hFF);

    // Zero-length job.
    run_job(2'd0, 0, 100, 100, 100, 0, 4'hF);
    chk("zero_done_cyc", done_cyc, 0);

    // Randomized readiness across modes.
    fill_random();
    run_job(2'd0, 100, 50, 100, 100, 0, 4'hF);
    fill_random();
    run_job(2'd1, 40, 60, 60, 60, 0, 4'hF);
    fill_random();
    run_job(2'd2, 40, 60, 60, 60, 0, 4'hF);
    fill_random();
    run_job(2'd3, 20, 70, 30, 50, 0, 4'hF);

    // Reset mid-job after three pops.
    fill_random();
    mode = 2'd0;
    num_words = CW'(10);
    stream_read_ready = 1'b1;
    buffer_read_ready = 1'b1;
    stream_write_ready = 4'hF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_words_read", words_read, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_reqs",
        {stream_read_req, buffer_read_req, stream_write_req}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_state", {busy, state}, 3'b000);
    chk("post_rst_counts", {words_read, words_written}, 0);
    @(posedge clk); #1;
    run_job(2'd0, 2, 100, 100, 100, 0, 4'hF);
    chk("post_rst_pushes", got_mask.size(), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
